// File: rtl/logic_slice_seq.sv
// rtl/logic_slice_seq.sv - slice-serial AND/OR/XOR/PASS_A logic unit with optional inversion
// Operands are latched at accept. SLICE result bits are built per cycle, LSB slice first.
module logic_slice_seq #(
  parameter int WIDTH = 8,
  parameter int SLICE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_zero
);

  localparam int NS = WIDTH / SLICE;
  localparam int CW = (NS > 1) ? $clog2(NS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               zero_q, zero_d;
  logic [SLICE-1:0]   a_s, b_s, r_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    res_d     = res_q;
    zero_d    = zero_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    a_s       = '0;
    b_s       = '0;
    r_s       = '0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          op_d    = in_op;
          a_d     = in_a;
          b_d     = in_b;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        // Constant-index slice mux keeps the part-selects static.
        for (int k = 0; k < NS; k++) begin
          if (cnt_q == CW'(k)) begin
            a_s = a_q[k*SLICE +: SLICE];
            b_s = b_q[k*SLICE +: SLICE];
          end
        end
        case (op_q[1:0])
          2'b00:   r_s = a_s & b_s;
          2'b01:   r_s = a_s | b_s;
          2'b10:   r_s = a_s ^ b_s;
          default: r_s = a_s;
        endcase
        r_s = r_s ^ {SLICE{op_q[2]}};
        for (int k = 0; k < NS; k++) begin
          if (cnt_q == CW'(k)) begin
            acc_d[k*SLICE +: SLICE] = r_s;
          end
        end
        // The working accumulator is published only when complete, so out_res holds in RUN.
        if (cnt_q == CW'(NS - 1)) begin
          res_d   = acc_d;
          zero_d  = (acc_d == '0);
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign out_res  = res_q;
  assign out_zero = zero_q;

endmodule

// File: tb/tb_logic_slice_seq.sv
// tb/tb_logic_slice_seq.sv - directed-vector bench for logic_slice_seq
// Default 8/2 instance plus 16/1 and 16/16 instances for latency extremes.
module tb_logic_slice_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_op = 3'b000;
  logic [7:0] in_a = 8'h00;
  logic [7:0] in_b = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_res;
  logic       out_zero;

  logic        w_valid_s = 1'b0, w_valid_f = 1'b0;
  logic        w_ready_s, w_ready_f, w_ovalid_s, w_ovalid_f;
  logic        w_oready = 1'b0;
  logic [2:0]  w_op = 3'b000;
  logic [15:0] w_a = 16'h0, w_b = 16'h0;
  logic [15:0] w_res_s, w_res_f;
  logic        w_zero_s, w_zero_f;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  logic_slice_seq #(.WIDTH(8), .SLICE(2)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_zero(out_zero)
  );

  logic_slice_seq #(.WIDTH(16), .SLICE(1)) u_dut_s (
    .clk(clk), .rst(rst), .in_valid(w_valid_s), .in_ready(w_ready_s), .in_op(w_op),
    .in_a(w_a), .in_b(w_b), .out_valid(w_ovalid_s), .out_ready(w_oready),
    .out_res(w_res_s), .out_zero(w_zero_s)
  );

  logic_slice_seq #(.WIDTH(16), .SLICE(16)) u_dut_f (
    .clk(clk), .rst(rst), .in_valid(w_valid_f), .in_ready(w_ready_f), .in_op(w_op),
    .in_a(w_a), .in_b(w_b), .out_valid(w_ovalid_f), .out_ready(w_oready),
    .out_res(w_res_f), .out_zero(w_zero_f)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accepts one request on the default instance, measures latency, checks result, drains it.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] exp_res, input logic exp_zero);
    int lat;
    lat = 0;
    while (!in_ready && lat < 50) begin
      step();
      lat++;
    end
    chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
    in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      step();
      lat++;
    end
    chk({tag, "_lat"}, lat, 32'd4);
    chk({tag, "_res"}, {24'd0, out_res}, {24'd0, exp_res});
    chk({tag, "_zero"}, {31'd0, out_zero}, {31'd0, exp_zero});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_idle"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run16(input string tag, input bit full, input logic [2:0] op,
                       input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp_res,
                       input int exp_lat);
    int lat;
    w_op = op; w_a = a; w_b = b;
    if (full) w_valid_f = 1'b1; else w_valid_s = 1'b1;
    step();
    w_valid_f = 1'b0; w_valid_s = 1'b0;
    w_a = ~a; w_b = ~b; w_op = ~op;
    lat = 0;
    while (!(full ? w_ovalid_f : w_ovalid_s) && lat < 50) begin
      step();
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_res"}, {16'd0, (full ? w_res_f : w_res_s)}, {16'd0, exp_res});
    chk({tag, "_zero"}, {31'd0, (full ? w_zero_f : w_zero_s)}, {31'd0, (exp_res == 16'h0)});
    w_oready = 1'b1;
    step();
    w_oready = 1'b0;
  endtask

  logic [7:0] bb_exp [3];
  logic [2:0] bb_op  [3];
  int         bb_t   [3];

  initial begin
    step();
    step();
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_res", {24'd0, out_res}, 32'd0);
    chk("rst_zero", {31'd0, out_zero}, 32'd0);
    rst = 1'b0;

    // Reset during the second RUN cycle discards the operation.
    in_op = 3'b000; in_a = 8'hFF; in_b = 8'h0F; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("midrst_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_res", {24'd0, out_res}, 32'd0);
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("midrst_novalid", {31'd0, out_valid}, 32'd0);
      step();
    end
    do_op("after_rst", 3'b000, 8'hFF, 8'h0F, 8'h0F, 1'b0);

    do_op("and",  3'b000, 8'hCA, 8'h5F, 8'h4A, 1'b0);
    do_op("or",   3'b001, 8'hCA, 8'h5F, 8'hDF, 1'b0);
    do_op("xor",  3'b010, 8'hCA, 8'h5F, 8'h95, 1'b0);
    do_op("pass", 3'b011, 8'hCA, 8'h5F, 8'hCA, 1'b0);
    do_op("nota", 3'b111, 8'hFF, 8'h00, 8'h00, 1'b1);
    do_op("xnor", 3'b110, 8'h3C, 8'h3C, 8'hFF, 1'b0);
    do_op("nand", 3'b100, 8'hCA, 8'h5F, 8'hB5, 1'b0);

    // Backpressure: DONE holds while inputs wiggle.
    in_op = 3'b010; in_a = 8'hA5; in_b = 8'h0F; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_a = 8'h00;
    for (int i = 0; i < 4; i++) step();
    chk("bp_valid0", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      in_a = 8'(i * 37); in_valid = 1'b1;
      step();
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_res", {24'd0, out_res}, 32'h000000AA);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_rel_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_rel_valid", {31'd0, out_valid}, 32'd0);

    // Back-to-back: in_valid and out_ready held high, requests advance on accept.
    bb_op[0] = 3'b000; bb_exp[0] = 8'h4A;
    bb_op[1] = 3'b001; bb_exp[1] = 8'hDF;
    bb_op[2] = 3'b010; bb_exp[2] = 8'h95;
    in_a = 8'hCA; in_b = 8'h5F; in_op = bb_op[0];
    in_valid = 1'b1; out_ready = 1'b1;
    begin
      int nreq, nres;
      nreq = 0; nres = 0;
      for (int c = 0; c < 60 && nres < 3; c++) begin
        if (out_valid) begin
          chk("b2b_res", {24'd0, out_res}, {24'd0, bb_exp[nres]});
          bb_t[nres] = c;
          nres++;
        end
        if (in_ready && nreq < 3) begin
          step();
          nreq++;
          if (nreq < 3) in_op = bb_op[nreq]; else in_valid = 1'b0;
        end else begin
          step();
        end
      end
      chk("b2b_count", nres, 32'd3);
      chk("b2b_gap1", bb_t[1] - bb_t[0], 32'd6);
      chk("b2b_gap2", bb_t[2] - bb_t[1], 32'd6);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    step();

    run16("s_and",  1'b0, 3'b000, 16'hA5C3, 16'h0FF0, 16'h05C0, 16);
    run16("s_xnor", 1'b0, 3'b110, 16'hA5C3, 16'h0FF0, 16'h55CC, 16);
    run16("s_nota", 1'b0, 3'b111, 16'hFFFF, 16'h1234, 16'h0000, 16);
    run16("f_or",   1'b1, 3'b001, 16'hA5C3, 16'h0FF0, 16'hAFF3, 1);
    run16("f_nand", 1'b1, 3'b100, 16'hA5C3, 16'h0FF0, 16'hFA3F, 1);
    run16("f_pass", 1'b1, 3'b011, 16'hA5C3, 16'h0FF0, 16'hA5C3, 1);
    run16("f_nota", 1'b1, 3'b111, 16'hA5C3, 16'h0FF0, 16'h5A3C, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
